alu_serial_scheduler: RTL and testbench
=======================================

Name: alu_serial_scheduler

Overview:
- Shares one combinational one-bit ALU slice between two requesters.
- Each requester submits an operation code (m, s) and two WIDTH-bit operands. The block arbitrates round-robin and sequences the operands LSB-first through the slice, one bit per clock. It assembles the WIDTH-bit result and returns it to the granted requester with a done pulse.
- Sits between the requesting control logic and the OneBitALU slice; it owns every slice input.

Parameters:
- WIDTH, 8, operand/result width; legal range 2..32.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  request per requester; level, held until that requester's done.
- op_m0, op_m1  in  1  mode for requester 0/1; sampled at grant.
- op_s0, op_s1  in  2  select for requester 0/1; sampled at grant.
- opa0, opa1  in  WIDTH  operand A for requester 0/1; sampled at grant.
- opb0, opb1  in  WIDTH  operand B for requester 0/1; sampled at grant.
- grant  out  2  one-hot, one-cycle pulse when a request is accepted.
- busy  out  1  high from the grant cycle through the done cycle.
- done  out  2  one-hot, one-cycle pulse; result valid this cycle.
- result  out  WIDTH  assembled result; holds its last value until the next done.
- alu_m  out  1  slice mode.
- alu_s  out  2  slice select.
- alu_a  out  1  slice operand A bit.
- alu_b  out  1  slice operand B bit.
- alu_f  in  1  slice output; combinational from alu_m, alu_s, alu_a, alu_b.

Behaviour:
- Reset (reset_n low, async): state IDLE; grant, done, busy = 0; result = 0; alu_m, alu_s, alu_a, alu_b = 0; bit counter = 0; round-robin pointer = requester 0 has priority.
- States: IDLE, RUN, DONE.
- IDLE, any req bit high:
  - Pick the requester per the pointer: if both request, the pointer wins; if one requests, it wins.
  - Pulse grant for that requester.
  - Latch its m, s, A and B into internal registers.
  - Clear the counter and enter RUN.
  - busy rises in this grant cycle.
- RUN, cycle k (k = 0..WIDTH-1):
  - alu_m, alu_s = latched op; alu_a = A[k]; alu_b = B[k]. All are registered outputs.
  - At the end of cycle k, shift alu_f into the result shift register at bit k.
  - After k = WIDTH-1, enter DONE.
- DONE:
  - result = assembled value; pulse done for the owner.
  - Pointer moves to the other requester.
  - Return to IDLE; busy drops at the end of this cycle.
- Latency: grant at cycle 0; RUN occupies cycles 1..WIDTH; done at cycle WIDTH+1. Back-to-back throughput is one operation per WIDTH+3 cycles (IDLE re-arbitration cycle included).
- req is not rechecked during RUN or DONE:
  - A dropped req does not abort the operation.
  - A new req waits for IDLE.
  - A requester must drop req on its done cycle; if req is still high in the following IDLE, it is treated as a new request.
- Slice inputs outside RUN: hold 0.
- Simultaneous req from both requesters in IDLE: exactly one grant; the other is served next, with no starvation.
- Reset mid-RUN: the operation is discarded; no done is issued and all outputs return to reset values immediately.
- Counter width: $clog2(WIDTH) bits. Wrap is never used; the count terminates at WIDTH-1.

Decomposition:
- Shared package:
  - state enum: IDLE, RUN, DONE.
  - opcode field widths: M_W = 1, S_W = 2.
  - localparam encodings for the slice ops used by the bench.
- One natural sub-module, rr_arbiter2: two-requester round-robin picker with the pointer update on done.
- The OneBitALU slice stays external and is instantiated alongside, not inside, this block.

Test Plan:
Bench slice model for these scenarios: m=0: s=0 AND, s=1 OR, s=2 XOR, s=3 NOT a; m=1 passes a.
- Single op: req=2'b01, m=0, s=0, A=8'hF0, B=8'h3C.
  - Required: grant=01 at cycle 0; alu_a sequence LSB-first 0,0,0,0,1,1,1,1.
  - Required: done=01 at cycle 9; result=8'h30.
- Contention: req=2'b11 from reset.
  - Requester 0 (XOR, 8'hAA ^ 8'h0F): grant 01 first, done with result 8'hA5.
  - Requester 1 (OR, 8'h11 | 8'h22): granted next, done with 8'h33.
  - Next contention: requester 1 wins first.
- Hold-off: requester 1 raises req during requester 0's RUN.
  - Required: no grant until IDLE; requester 0's result is unaffected.
- Reset mid-RUN: reset_n low at cycle 4 of RUN.
  - Required: done never pulses; result=0; busy=0; next req starts cleanly.
- Pass/NOT checks:
  - m=1, A=8'h5A -> 8'h5A.
  - m=0, s=3, A=8'h5A -> 8'hA5.
  - WIDTH=4 build: done at cycle 5.

Source files
------------

// File: rtl/alu_serial_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_scheduler_pkg
// Description : Shared types and constants for the serial ALU scheduler:
//               FSM state encoding, opcode field widths and slice op codes.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_serial_scheduler_pkg;

    // Opcode field widths (mode and select)
    localparam int c_M_W = 1;
    localparam int c_S_W = 2;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Slice mode: logic ops or pass-through of operand A
    localparam logic [c_M_W-1:0] c_M_LOGIC = 1'b0;
    localparam logic [c_M_W-1:0] c_M_PASS  = 1'b1;

    // Slice select in logic mode
    localparam logic [c_S_W-1:0] c_S_AND = 2'd0;
    localparam logic [c_S_W-1:0] c_S_OR  = 2'd1;
    localparam logic [c_S_W-1:0] c_S_XOR = 2'd2;
    localparam logic [c_S_W-1:0] c_S_NOT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/alu_serial_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_scheduler_if
// Description : Bundle of the two requester ports and the one-bit slice
//               ports. The scheduler uses the slave view; the requesters and
//               the slice together form the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_serial_scheduler_if #(
    parameter int WIDTH = 8
);
    import alu_serial_scheduler_pkg::*;

    // Requester side
    logic [1:0]       req;
    logic [c_M_W-1:0] op_m0;
    logic [c_M_W-1:0] op_m1;
    logic [c_S_W-1:0] op_s0;
    logic [c_S_W-1:0] op_s1;
    logic [WIDTH-1:0] opa0;
    logic [WIDTH-1:0] opa1;
    logic [WIDTH-1:0] opb0;
    logic [WIDTH-1:0] opb1;
    logic [1:0]       grant;
    logic             busy;
    logic [1:0]       done;
    logic [WIDTH-1:0] result;

    // One-bit slice side
    logic [c_M_W-1:0] alu_m;
    logic [c_S_W-1:0] alu_s;
    logic             alu_a;
    logic             alu_b;
    logic             alu_f;

    modport slave (
        input  req, op_m0, op_m1, op_s0, op_s1, opa0, opa1, opb0, opb1, alu_f,
        output grant, busy, done, result, alu_m, alu_s, alu_a, alu_b
    );

    modport master (
        output req, op_m0, op_m1, op_s0, op_s1, opa0, opa1, opb0, opb1, alu_f,
        input  grant, busy, done, result, alu_m, alu_s, alu_a, alu_b
    );

endinterface
`default_nettype wire

// File: rtl/alu_serial_scheduler_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester round-robin picker. The pick is combinational
//               from the request vector and the priority pointer; the
//               pointer moves to the other requester when an operation ends.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic [1:0] i_req,
    input  wire logic       i_advance,   // one-cycle pulse at end of an operation
    input  wire logic       i_owner,     // index of the requester that finished
    output logic [1:0]      o_pick
);

    logic r_ptr;  // index of the requester holding priority on a tie

    // Pointer hands priority to the requester that did not just finish
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= ~i_owner;
        end
    end

    // A lone requester always wins; on a tie the pointer decides
    always_comb begin
        o_pick = 2'b00;
        case (i_req)
            2'b01:   o_pick = 2'b01;
            2'b10:   o_pick = 2'b10;
            2'b11:   o_pick = r_ptr ? 2'b10 : 2'b01;
            default: o_pick = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_serial_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_scheduler
// Description : Shares an external one-bit ALU slice between two requesters.
//               Arbitrates round-robin, feeds operand bits LSB-first through
//               the slice one per clock, assembles the result and returns it
//               with a done pulse to the granted requester.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_scheduler
    import alu_serial_scheduler_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    alu_serial_scheduler_if.slave   bus
);

    localparam int             c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    state_t           r_state;
    logic [c_CW-1:0]  r_cnt;     // index of the bit currently on the slice
    logic             r_primed;  // slice carries a live bit this cycle
    logic [1:0]       r_owner;   // one-hot owner of the running operation
    logic [c_M_W-1:0] r_m;
    logic [c_S_W-1:0] r_s;
    logic [WIDTH-1:0] r_a;       // operand A, shifted right as bits are issued
    logic [WIDTH-1:0] r_b;       // operand B, shifted right as bits are issued
    logic [WIDTH-1:0] r_res;     // result shift register, filled from the MSB

    logic [1:0]       w_pick;
    logic             w_advance;

    assign w_advance = (r_state == ST_DONE);

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (bus.req),
        .i_advance (w_advance),
        .i_owner   (r_owner[1]),
        .o_pick    (w_pick)
    );

    // Scheduler FSM: arbitrate, stream bits through the slice, report result.
    // The first RUN cycle only primes the slice registers, so bit k is on the
    // slice in cycle k+1 after grant and is captured at the end of that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_primed   <= 1'b0;
            r_owner    <= 2'b00;
            r_m        <= '0;
            r_s        <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            bus.grant  <= 2'b00;
            bus.done   <= 2'b00;
            bus.busy   <= 1'b0;
            bus.result <= '0;
            bus.alu_m  <= '0;
            bus.alu_s  <= '0;
            bus.alu_a  <= 1'b0;
            bus.alu_b  <= 1'b0;
        end else begin
            bus.grant <= 2'b00;
            bus.done  <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        bus.grant <= w_pick;
                        bus.busy  <= 1'b1;
                        r_owner   <= w_pick;
                        if (w_pick[1]) begin
                            r_m <= bus.op_m1;
                            r_s <= bus.op_s1;
                            r_a <= bus.opa1;
                            r_b <= bus.opb1;
                        end else begin
                            r_m <= bus.op_m0;
                            r_s <= bus.op_s0;
                            r_a <= bus.opa0;
                            r_b <= bus.opb0;
                        end
                        r_cnt    <= '0;
                        r_primed <= 1'b0;
                        r_state  <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (r_primed) begin
                        r_res <= {bus.alu_f, r_res[WIDTH-1:1]};
                    end
                    if (r_primed && (r_cnt == c_LAST)) begin
                        bus.result <= {bus.alu_f, r_res[WIDTH-1:1]};
                        bus.done   <= r_owner;
                        bus.alu_m  <= '0;
                        bus.alu_s  <= '0;
                        bus.alu_a  <= 1'b0;
                        bus.alu_b  <= 1'b0;
                        r_state    <= ST_DONE;
                    end else begin
                        bus.alu_m <= r_m;
                        bus.alu_s <= r_s;
                        bus.alu_a <= r_a[0];
                        bus.alu_b <= r_b[0];
                        r_a       <= r_a >> 1;
                        r_b       <= r_b >> 1;
                        if (r_primed) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        r_primed <= 1'b1;
                    end
                end

                ST_DONE: begin
                    bus.busy <= 1'b0;
                    r_state  <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial_scheduler
// Description : Randomized self-checking bench. A word-level reference model
//               (arbitration pointer, pending set, operand table) predicts
//               grants, slice bit streams, done timing and results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_scheduler;
    import alu_serial_scheduler_pkg::*;

    localparam int WIDTH  = 8;
    localparam int WIDTH4 = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    // 100 MHz clock
    always #5 clk = ~clk;

    alu_serial_scheduler_if #(.WIDTH(WIDTH))  bus  ();
    alu_serial_scheduler_if #(.WIDTH(WIDTH4)) bus4 ();

    alu_serial_scheduler #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    alu_serial_scheduler #(.WIDTH(WIDTH4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    // One-bit slice behaviour
    function automatic logic slice_f(input logic m, input logic [1:0] s,
                                     input logic a, input logic b);
        if (m) return a;
        case (s)
            c_S_AND: return a & b;
            c_S_OR:  return a | b;
            c_S_XOR: return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign bus.alu_f  = slice_f(bus.alu_m,  bus.alu_s,  bus.alu_a,  bus.alu_b);
    assign bus4.alu_f = slice_f(bus4.alu_m, bus4.alu_s, bus4.alu_a, bus4.alu_b);

    // Whole-word result of an operation
    function automatic logic [WIDTH-1:0] ref_word(input logic m, input logic [1:0] s,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        if (m) return a;
        case (s)
            c_S_AND: return a & b;
            c_S_OR:  return a | b;
            c_S_XOR: return a ^ b;
            default: return ~a;
        endcase
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int               ptr;
    bit               pend [2];
    logic             m_op [2];
    logic [1:0]       s_op [2];
    logic [WIDTH-1:0] a_op [2];
    logic [WIDTH-1:0] b_op [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_ops(input int idx, input logic m, input logic [1:0] s,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (idx == 0) begin
            bus.op_m0 = m; bus.op_s0 = s; bus.opa0 = a; bus.opb0 = b;
        end else begin
            bus.op_m1 = m; bus.op_s1 = s; bus.opa1 = a; bus.opb1 = b;
        end
    endtask

    task automatic set_op(input int idx, input logic m, input logic [1:0] s,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        m_op[idx] = m; s_op[idx] = s; a_op[idx] = a; b_op[idx] = b;
        drive_ops(idx, m, s, a, b);
        bus.req[idx] = 1'b1;
        pend[idx]    = 1'b1;
    endtask

    task automatic set_random_op(input int idx);
        set_op(idx, 1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
               WIDTH'($urandom), WIDTH'($urandom));
    endtask

    // Serve every pending request; optionally raise a late request from
    // requester late_idx while another operation is running.
    task automatic serve_pending(input int late_idx);
        int               guard;
        int               win;
        logic [1:0]       exp_grant;
        logic [WIDTH-1:0] exp_res;
        while (pend[0] || pend[1]) begin
            guard = 0;
            do begin
                @(posedge clk); #1;
                guard++;
            end while (bus.grant == 2'b00 && guard < 40);
            if (pend[0] && pend[1]) win = ptr;
            else                    win = pend[0] ? 0 : 1;
            exp_grant = (win == 0) ? 2'b01 : 2'b10;
            chk("grant", 32'({bus.busy, bus.grant}), 32'({1'b1, exp_grant}));
            if (bus.grant == 2'b00) return;
            exp_res = ref_word(m_op[win], s_op[win], a_op[win], b_op[win]);
            // operands must have been latched at grant
            drive_ops(win, 1'($urandom), 2'($urandom), WIDTH'($urandom), WIDTH'($urandom));
            for (int k = 0; k < WIDTH; k++) begin
                @(posedge clk); #1;
                if (k == 3 && late_idx >= 0 && late_idx != win) begin
                    set_random_op(late_idx);
                    late_idx = -1;
                end
                chk("slice_bit",
                    32'({bus.busy, bus.grant, bus.done, bus.alu_m, bus.alu_s, bus.alu_a, bus.alu_b}),
                    32'({1'b1, 2'b00, 2'b00, m_op[win], s_op[win], a_op[win][k], b_op[win][k]}));
            end
            @(posedge clk); #1;
            chk("done", 32'({bus.busy, bus.done, bus.alu_a, bus.alu_b}), 32'({1'b1, exp_grant, 2'b00}));
            chk("result", 32'(bus.result), 32'(exp_res));
            bus.req[win] = 1'b0;
            pend[win]    = 1'b0;
            ptr          = 1 - win;
            @(posedge clk); #1;
            chk("idle_after_done", 32'({bus.busy, bus.done, bus.grant}), 32'(0));
        end
    endtask

    initial begin
        int guard;
        int cyc;
        int pat;
        int late;

        ptr = 0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        bus.req  = 2'b00;
        bus4.req = 2'b00;
        drive_ops(0, 1'b0, 2'b00, '0, '0);
        drive_ops(1, 1'b0, 2'b00, '0, '0);
        bus4.op_m0 = 1'b0; bus4.op_s0 = 2'b00; bus4.opa0 = '0; bus4.opb0 = '0;
        bus4.op_m1 = 1'b0; bus4.op_s1 = 2'b00; bus4.opa1 = '0; bus4.opb1 = '0;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state",
            32'({bus.grant, bus.done, bus.busy, bus.alu_m, bus.alu_s, bus.alu_a, bus.alu_b, bus.result}),
            32'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Contention from reset: requester 0 first, then requester 1
        set_op(0, c_M_LOGIC, c_S_XOR, 8'hAA, 8'h0F);
        set_op(1, c_M_LOGIC, c_S_OR,  8'h11, 8'h22);
        serve_pending(-1);

        // Single op from requester 0
        set_op(0, c_M_LOGIC, c_S_AND, 8'hF0, 8'h3C);
        serve_pending(-1);

        // Next contention: requester 1 now holds priority
        set_op(0, c_M_LOGIC, c_S_AND, 8'h0F, 8'hFF);
        set_op(1, c_M_LOGIC, c_S_XOR, 8'h33, 8'h55);
        serve_pending(-1);

        // Hold-off: pass-through on requester 0, late request on requester 1
        set_op(0, c_M_PASS, c_S_AND, 8'h5A, 8'h00);
        serve_pending(1);

        // NOT of operand A
        set_op(1, c_M_LOGIC, c_S_NOT, 8'h5A, 8'hC3);
        serve_pending(-1);

        // Reset in the middle of RUN
        set_op(0, c_M_LOGIC, c_S_OR, 8'hFF, 8'hFF);
        guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (bus.grant == 2'b00 && guard < 40);
        chk("rst_run_grant", 32'(bus.grant), 32'(2'b01));
        repeat (4) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_run",
            32'({bus.grant, bus.done, bus.busy, bus.alu_m, bus.alu_s, bus.alu_a, bus.alu_b, bus.result}),
            32'(0));
        bus.req = 2'b00;
        pend[0] = 1'b0; pend[1] = 1'b0;
        ptr     = 0;
        cyc     = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done != 2'b00) cyc++;
            if (i == 3) reset_n = 1'b1;
        end
        chk("rst_no_done", 32'({cyc, bus.busy, bus.result}), 32'(0));

        // Clean start after reset
        set_op(1, c_M_LOGIC, c_S_AND, 8'hC3, 8'h7E);
        serve_pending(-1);

        // Randomized traffic
        for (int r = 0; r < 20; r++) begin
            pat = $urandom_range(1, 3);
            if (pat[0]) set_random_op(0);
            if (pat[1]) set_random_op(1);
            late = -1;
            if (pat != 3 && $urandom_range(0, 1) == 1) late = pat[0] ? 1 : 0;
            serve_pending(late);
        end

        // Narrow build: done five cycles after grant
        bus4.op_m0 = c_M_LOGIC;
        bus4.op_s0 = c_S_XOR;
        bus4.opa0  = 4'h9;
        bus4.opb0  = 4'h5;
        bus4.req   = 2'b01;
        guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (bus4.grant == 2'b00 && guard < 40);
        chk("w4_grant", 32'(bus4.grant), 32'(2'b01));
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (bus4.done == 2'b00 && cyc < 20);
        chk("w4_done_cycle", 32'(cyc), 32'(5));
        chk("w4_result", 32'({bus4.done, bus4.result}), 32'({2'b01, 4'hC}));
        bus4.req = 2'b00;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
